// File: rtl/uart_tx_framed_pkg.sv
// Shared types and constants for the framed UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2,
    PARITY_RSVD = 2'd3
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MAX_FRAME_BITS = 13;
  localparam int BIT_CNT_W      = $clog2(MAX_FRAME_BITS);

  // xor_of_data is the XOR reduction of the data word
  function automatic logic parity_bit(parity_t mode, logic xor_of_data);
    return (mode == PARITY_ODD) ? ~xor_of_data : xor_of_data;
  endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// Word handshake, frame configuration and line/status signals of the transmitter.
interface uart_tx_framed_if #(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_BITS = 8
);
  logic [DIV_WIDTH-1:0] divisor;
  logic [1:0]           parity_mode;
  logic                 two_stop;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic                 tx;

  modport master (
    output divisor, parity_mode, two_stop, data, valid,
    input  ready, busy, done, tx
  );

  modport slave (
    input  divisor, parity_mode, two_stop, data, valid,
    output ready, busy, done, tx
  );
endinterface

// File: rtl/uart_tx_framed_baud_gen.sv
// Bit-period down-counter; bit_tick_o marks the last clock of each bit period.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 bit_tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = divisor_i;
    end else if (!run_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = divisor_i;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_tick_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_framed.sv
// Runtime-configurable UART transmitter: start, DATA_BITS data LSB first,
// optional parity, one or two stop bits.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_BITS = 8
) (
  input logic             clk,
  input logic             rst,
  uart_tx_framed_if.slave bus
);

  // state  | meaning
  // IDLE   | line high, ready for a word
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | parity bit, only when parity is odd/even
  // STOP   | one or two stop bits (high)

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DIV_WIDTH-1:0] div_q, baud_div;
  parity_t              pm_q, pm_in;
  logic                 two_q, par_q;
  logic                 tx_q, tx_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d, last_bit;
  logic                 accept, bit_tick, par_en, run, done;

  assign pm_in    = parity_t'(bus.parity_mode);
  assign accept   = bus.valid && bus.ready;
  assign run      = (state_q != IDLE);
  assign baud_div = accept ? bus.divisor : div_q;
  assign par_en   = (pm_q == PARITY_ODD) || (pm_q == PARITY_EVEN);

  // Frame bit index of the final stop bit; index 0 is the start bit
  assign last_bit = BIT_CNT_W'(DATA_BITS) + BIT_CNT_W'(par_en)
                  + (two_q ? BIT_CNT_W'(2) : BIT_CNT_W'(1));

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept),
    .run_i      (run),
    .divisor_i  (baud_div),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_tick ? bit_cnt_q + 1'b1 : bit_cnt_q;
    done      = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        sh_d    = bus.data;
      end
      START: if (bit_tick) state_d = DATA;
      DATA: if (bit_tick) begin
        sh_d = sh_q >> 1;
        if (bit_cnt_q == BIT_CNT_W'(DATA_BITS)) state_d = par_en ? PARITY : STOP;
      end
      PARITY: if (bit_tick) state_d = STOP;
      STOP: if (bit_tick && (bit_cnt_q == last_bit)) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) bit_cnt_d = '0;

    // Line level follows the next state so tx only moves at bit boundaries
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      div_q     <= '0;
      pm_q      <= PARITY_NONE;
      two_q     <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      if (accept) begin
        div_q <= bus.divisor;
        pm_q  <= pm_in;
        two_q <= bus.two_stop;
        par_q <= parity_bit(pm_in, ^bus.data);
      end
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = run;
  assign bus.ready = !run;
  assign bus.done  = done;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: frame shapes, parity, back-to-back, reset, config latching.
module tb_uart_tx_framed;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_framed_if #(.DIV_WIDTH(16), .DATA_BITS(8)) bus ();

  uart_tx_framed #(.DIV_WIDTH(16), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // exp_bits holds the hand-built frame, bit 0 = start bit, upper unused bits = 1.
  // At cycle chg_at (0 = never) divisor/parity_mode are changed while the frame runs.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [15:0] div,
                           input logic [1:0] pm, input logic two, input logic [12:0] exp_bits,
                           input int exp_n, input int chg_at);
    int   c, idx, done_cnt, done_at, tx_bad, busy_len;
    logic first_ready;
    @(negedge clk);
    bus.data        = d;
    bus.divisor     = div;
    bus.parity_mode = pm;
    bus.two_stop    = two;
    bus.valid       = 1'b1;
    @(negedge clk);
    bus.valid   = 1'b0;
    first_ready = bus.ready;
    c = 1; done_cnt = 0; done_at = 0; tx_bad = 0;
    while (bus.busy && c <= 400) begin
      idx = (c - 1) / (int'(div) + 1);
      if (idx > 12) tx_bad++;
      else if (bus.tx !== exp_bits[idx]) tx_bad++;
      if (bus.done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == chg_at) begin
        bus.divisor     = 16'd1;
        bus.parity_mode = 2'd1;
      end
      c++;
      @(negedge clk);
    end
    busy_len = c - 1;
    check_eq({tag, "_ready_drop"}, first_ready, 1'b0);
    check_eq({tag, "_busy_len"}, busy_len, exp_n * (int'(div) + 1));
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_pos"}, done_at, exp_n * (int'(div) + 1));
    check_eq({tag, "_tx_bad"}, tx_bad, 0);
    check_eq({tag, "_tx_idle"}, bus.tx, 1'b1);
  endtask

  logic       txs  [1:42];
  logic       rdys [1:42];
  logic [9:0] f1, f2;
  int         bad, rdy_cnt;
  logic       exp_bit;

  initial begin
    rst             = 1'b1;
    bus.valid       = 1'b0;
    bus.data        = '0;
    bus.divisor     = '0;
    bus.parity_mode = '0;
    bus.two_stop    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_tx", bus.tx, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_ready", bus.ready, 1'b1);
    check_eq("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    run_frame("8n1_a5",  8'hA5, 16'd3, 2'd0, 1'b0, {3'b111, 1'b1, 8'hA5, 1'b0}, 10, 0);
    run_frame("even_a5", 8'hA5, 16'd3, 2'd2, 1'b0, {3'b111, 1'b0, 8'hA5, 1'b0}, 11, 0);
    run_frame("odd_a5",  8'hA5, 16'd3, 2'd1, 1'b0, {3'b111, 1'b1, 8'hA5, 1'b0}, 11, 0);
    run_frame("rsvd_a5", 8'hA5, 16'd3, 2'd3, 1'b0, {3'b111, 1'b1, 8'hA5, 1'b0}, 10, 0);
    run_frame("2stop_00", 8'h00, 16'd0, 2'd0, 1'b1, {4'b1111, 8'h00, 1'b0}, 11, 0);

    // Back-to-back with valid held: 8'h01 then 8'h80, divisor 1, 8N1
    @(negedge clk);
    bus.data        = 8'h01;
    bus.divisor     = 16'd1;
    bus.parity_mode = 2'd0;
    bus.two_stop    = 1'b0;
    bus.valid       = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      txs[c]  = bus.tx;
      rdys[c] = bus.ready;
      if (c == 1)  bus.data  = 8'h80;
      if (c == 22) bus.valid = 1'b0;
    end
    f1 = {1'b1, 8'h01, 1'b0};
    f2 = {1'b1, 8'h80, 1'b0};
    bad = 0; rdy_cnt = 0;
    for (int c = 1; c <= 42; c++) begin
      if (c <= 20)      exp_bit = f1[(c - 1) / 2];
      else if (c == 21) exp_bit = 1'b1;
      else if (c <= 41) exp_bit = f2[(c - 22) / 2];
      else              exp_bit = 1'b1;
      if (txs[c] !== exp_bit) bad++;
      if (c <= 41 && rdys[c] === 1'b1) rdy_cnt++;
    end
    check_eq("b2b_tx_bad", bad, 0);
    check_eq("b2b_ready_cnt", rdy_cnt, 1);
    check_eq("b2b_ready_gap", rdys[21], 1'b1);
    check_eq("b2b_gap_high", txs[21], 1'b1);
    check_eq("b2b_start2", txs[22], 1'b0);

    // Reset during data bit 3 of 8'hFF
    @(negedge clk);
    bus.data        = 8'hFF;
    bus.divisor     = 16'd3;
    bus.parity_mode = 2'd0;
    bus.two_stop    = 1'b0;
    bus.valid       = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (13) @(negedge clk);
    check_eq("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tx", bus.tx, 1'b1);
    check_eq("mid_rst_busy", bus.busy, 1'b0);
    check_eq("mid_rst_ready", bus.ready, 1'b1);
    check_eq("mid_rst_done", bus.done, 1'b0);
    rst = 1'b0;
    run_frame("post_rst_ff", 8'hFF, 16'd3, 2'd0, 1'b0, {4'b1111, 8'hFF, 1'b0}, 10, 0);

    // Divisor/parity change mid-frame must not disturb the running frame
    run_frame("cfg_old", 8'hA5, 16'd3, 2'd2, 1'b0, {3'b111, 1'b0, 8'hA5, 1'b0}, 11, 10);
    run_frame("cfg_new", 8'hA5, 16'd1, 2'd1, 1'b0, {3'b111, 1'b1, 8'hA5, 1'b0}, 11, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
# uart_tx_framed

Parametrised, runtime-configurable UART transmitter with a valid/ready input handshake. Each accepted word is sent as one asynchronous serial frame: a start bit, DATA_BITS data bits LSB first, an optional odd or even parity bit, and one or two stop bits. The bit period comes from a runtime divisor input rather than a fixed parameter. It sits between a byte source (FIFO, command engine) and the board TX pin, and is the configurable successor to the fixed 8N1 transmitter.

## Interface
- DIV_WIDTH, 16: width of the baud divisor input.
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- divisor  in  DIV_WIDTH  bit period minus one, in clk cycles (867 gives 115200 baud at 100 MHz).
- parity_mode  in  2  0 none, 1 odd, 2 even, 3 reserved (treated as none).
- two_stop  in  1  1 selects two stop bits, 0 selects one.
- data  in  DATA_BITS  word to send.
- valid  in  1  data and configuration are presented.
- ready  out  1  transmitter can accept a word; equals !busy (combinational).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse in the final clk of the final stop bit.
- tx  out  1  serial line, idle high, registered.

## Operation
- Accept occurs when valid && ready at a rising edge. On that edge, data, divisor, parity_mode and two_stop are latched. Configuration changes mid-frame have no effect.
- valid while busy is ignored; no queueing.
- FSM states are IDLE, START, DATA, PARITY, STOP. Transitions:
  - IDLE→START on accept.
  - START→DATA after one bit period.
  - DATA→PARITY after DATA_BITS bit periods, or DATA→STOP if parity is none.
  - PARITY→STOP after one bit period.
  - STOP→IDLE after one or two bit periods.
- Line level per state: tx = 0 in START, data[i] LSB first in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
- Parity rules:
  - Odd: the data plus parity bit hold an odd count of ones.
  - Even: the data plus parity bit hold an even count of ones.
  - The parity bit is computed from the latched word at accept.
- Bit period is divisor+1 clocks. divisor = 0 gives a 1-clock bit; the maximum is 2^DIV_WIDTH clocks.
- Bit count arithmetic: bits per frame N = 1 + DATA_BITS + (parity ? 1 : 0) + (two_stop ? 2 : 1), range 7–13. The bit counter is 4 bits wide and never wraps within a frame.
- Reset in any state, including mid-frame:
  - Next edge gives tx = 1, busy = 0, done = 0, state IDLE, counters 0.
  - The partial frame is abandoned.
- Reset values: tx = 1, busy = 0, ready = 1, done = 0.

## Timing
- Accept at edge k: tx falls and busy rises at edge k; ready drops in the cycle after k.
- Start bit occupies cycles k+1 … k+(D+1), where D is the latched divisor.
- The frame lasts N·(D+1) cycles after edge k.
- done is high in the frame's last cycle. At the edge that ends that cycle, busy falls and tx stays 1.
- ready returns the cycle after the frame ends. An accept then can occur at the first edge after that, giving a minimum inter-frame gap of 0 extra bit periods and tx high for exactly one clock between back-to-back frames when valid is held.
- tx never glitches: it is a flop output that changes only at bit boundaries.

## Structure
- Package uart_pkg holds:
  - parity_t enum (PARITY_NONE, PARITY_ODD, PARITY_EVEN, PARITY_RSVD);
  - tx_state_t enum for the FSM states;
  - localparam MAX_FRAME_BITS = 13.
- Sub-module uart_baud_gen: a DIV_WIDTH down-counter.
  - Reloads divisor on start and on each tick.
  - Outputs a one-cycle bit_tick at the last clock of each bit period.
  - Held cleared when idle.
- Top level contains the FSM, bit counter, data shift register, parity computation and handshake.

## Test plan
- 8N1 (divisor = 3, parity_mode = 0, two_stop = 0), data 8'hA5:
  - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks;
  - busy high 40 cycles;
  - done pulses once in cycle 40.
- Parity, data 8'hA5 (four ones):
  - parity_mode = 2 gives parity bit 0; parity_mode = 1 gives parity bit 1;
  - frame length 44 cycles at divisor = 3.
- two_stop = 1, divisor = 0, DATA_BITS = 8, data 8'h00: frame is 11 clocks, with tx low for 9 clocks then high for 2.
- Back-to-back, valid held with data 8'h01 then 8'h80:
  - second start bit follows exactly one idle-high clock after the first frame ends;
  - ready is high only in that clock.
- Reset mid-frame: assert rst during bit 3 of 8'hFF:
  - next edge gives tx = 1, busy = 0, ready = 1;
  - a new accept after rst deasserts sends a complete, correct frame.
- Config change while busy: change divisor and parity_mode mid-frame; the current frame keeps its latched settings and the next frame uses the new ones.
